// File: rtl/mult_bus_master.sv
// mult_bus_master: runs one multiply job on the memory-mapped multiplier.
// For each job it writes A and B, sets init, polls done, reads the result
// and clears init, then presents the product for one cycle.
// All outputs, including the bus signals, are registered.
module mult_bus_master #(
    parameter int unsigned POLL_GAP  = 2,
    parameter int unsigned MAX_POLLS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        busy,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        error,
    output logic        cs,
    output logic [4:0]  addr,
    output logic        rd,
    output logic        wr,
    output logic [15:0] d_out,
    input  logic [31:0] d_in
);

    localparam int unsigned PCW = $clog2(MAX_POLLS + 1);
    localparam int unsigned GW  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    localparam logic [4:0] ADDR_A    = 5'h04;
    localparam logic [4:0] ADDR_B    = 5'h08;
    localparam logic [4:0] ADDR_INIT = 5'h0C;
    localparam logic [4:0] ADDR_RES  = 5'h10;
    localparam logic [4:0] ADDR_DONE = 5'h14;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_A,
        S_WR_B,
        S_WR_INIT,
        S_GAP,
        S_POLL,
        S_RD_RES,
        S_CLR_INIT,
        S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      op_a_q, op_a_d;
    logic [15:0]      op_b_q, op_b_d;
    logic [PCW-1:0]   poll_cnt_q, poll_cnt_d;
    logic [PCW-1:0]   poll_inc;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic             timeout_q, timeout_d;
    logic [31:0]      res_hold_q, res_hold_d;

    logic             busy_d, result_valid_d, error_d;
    logic [31:0]      result_d;
    logic             cs_d, rd_d, wr_d;
    logic [4:0]       addr_d;
    logic [15:0]      d_out_d;

    assign poll_inc = poll_cnt_q + PCW'(1);

    // State, job registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            poll_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            timeout_q    <= 1'b0;
            res_hold_q   <= '0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            error        <= 1'b0;
            cs           <= 1'b0;
            addr         <= '0;
            rd           <= 1'b0;
            wr           <= 1'b0;
            d_out        <= '0;
        end else begin
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            poll_cnt_q   <= poll_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            timeout_q    <= timeout_d;
            res_hold_q   <= res_hold_d;
            busy         <= busy_d;
            result       <= result_d;
            result_valid <= result_valid_d;
            error        <= error_d;
            cs           <= cs_d;
            addr         <= addr_d;
            rd           <= rd_d;
            wr           <= wr_d;
            d_out        <= d_out_d;
        end
    end

    // Next state, then outputs for the state being entered (Moore, registered)
    always_comb begin
        state_d        = state_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        poll_cnt_d     = poll_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        timeout_d      = timeout_q;
        res_hold_d     = res_hold_q;
        busy_d         = 1'b0;
        result_d       = result;
        result_valid_d = 1'b0;
        error_d        = error;
        cs_d           = 1'b0;
        rd_d           = 1'b0;
        wr_d           = 1'b0;
        addr_d         = '0;
        d_out_d        = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_a_d    = op_a;
                    op_b_d    = op_b;
                    timeout_d = 1'b0;
                    state_d   = S_WR_A;
                end
            end
            S_WR_A:    state_d = S_WR_B;
            S_WR_B:    state_d = S_WR_INIT;
            S_WR_INIT: begin
                poll_cnt_d = '0;
                gap_cnt_d  = GW'(POLL_GAP - 1);
                state_d    = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = S_POLL;
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            S_POLL: begin
                poll_cnt_d = poll_inc;
                if (d_in[0]) begin
                    state_d = S_RD_RES;
                end else if (poll_inc == PCW'(MAX_POLLS)) begin
                    timeout_d = 1'b1;
                    state_d   = S_CLR_INIT;
                end else begin
                    gap_cnt_d = GW'(POLL_GAP - 1);
                    state_d   = S_GAP;
                end
            end
            S_RD_RES: begin
                res_hold_d = d_in;
                state_d    = S_CLR_INIT;
            end
            S_CLR_INIT: state_d = S_FIN;
            S_FIN:      state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);

        unique case (state_d)
            S_WR_A: begin
                cs_d = 1'b1; wr_d = 1'b1; addr_d = ADDR_A; d_out_d = op_a_d;
            end
            S_WR_B: begin
                cs_d = 1'b1; wr_d = 1'b1; addr_d = ADDR_B; d_out_d = op_b_q;
            end
            S_WR_INIT: begin
                cs_d = 1'b1; wr_d = 1'b1; addr_d = ADDR_INIT; d_out_d = 16'h0001;
            end
            S_POLL: begin
                cs_d = 1'b1; rd_d = 1'b1; addr_d = ADDR_DONE;
            end
            S_RD_RES: begin
                cs_d = 1'b1; rd_d = 1'b1; addr_d = ADDR_RES;
            end
            S_CLR_INIT: begin
                cs_d = 1'b1; wr_d = 1'b1; addr_d = ADDR_INIT; d_out_d = 16'h0000;
            end
            S_FIN: begin
                result_valid_d = 1'b1;
                result_d       = timeout_q ? 32'h0 : res_hold_q;
                error_d        = timeout_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mult_bus_master.sv
// Testbench for mult_bus_master: multiplier peripheral model, per-cycle
// expectation built from the job timing rules, and directed jobs.
module tb_mult_bus_master;

    localparam int G = 2;
    localparam int M = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        busy, result_valid, error, cs, rd, wr;
    logic [31:0] result;
    logic [4:0]  addr;
    logic [15:0] d_out;
    logic [31:0] d_in;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    mult_bus_master #(.POLL_GAP(G), .MAX_POLLS(M)) dut (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .result(result), .result_valid(result_valid), .error(error),
        .cs(cs), .addr(addr), .rd(rd), .wr(wr), .d_out(d_out), .d_in(d_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Peripheral: captures A/B, counts done polls since init, done at poll done_after
    logic [15:0] p_a = '0, p_b = '0;
    int p_polls = 0;
    int done_after = 1;

    always @(posedge clk) begin
        if (cs && wr) begin
            if (addr == 5'h04) p_a <= d_out;
            if (addr == 5'h08) p_b <= d_out;
            if (addr == 5'h0C && d_out[0]) p_polls <= 0;
        end
        if (cs && rd && addr == 5'h14) p_polls <= p_polls + 1;
    end

    always_comb begin
        d_in = 32'h0;
        if (cs && rd && addr == 5'h10) d_in = 32'(p_a) * 32'(p_b);
        if (cs && rd && addr == 5'h14) d_in = {31'h0, (done_after != 0 && p_polls + 1 >= done_after)};
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model of the job and per-cycle compare of every output
    bit          m_active = 0;
    int          m_s = 0, m_k = 0;
    logic [15:0] m_a = '0, m_b = '0;
    logic [31:0] m_res = '0;
    bit          m_err = 0;

    initial begin
        int t, p, tt, fin;
        logic e_busy, e_rv, e_err, e_cs, e_rd, e_wr;
        logic [4:0]  e_addr;
        logic [15:0] e_dout;
        logic [31:0] e_res;
        forever begin
            @(negedge clk);
            t = cyc - m_s;
            p = (m_k != 0) ? m_k : M;
            tt = 3 + p * (G + 1);
            fin = (m_k != 0) ? tt + 3 : tt + 2;
            e_busy = 0; e_rv = 0; e_cs = 0; e_rd = 0; e_wr = 0;
            e_addr = '0; e_dout = '0; e_res = m_res; e_err = m_err;
            if (m_active && t >= 1 && t <= fin) begin
                e_busy = 1;
                if (t == 1) begin e_cs = 1; e_wr = 1; e_addr = 5'h04; e_dout = m_a; end
                else if (t == 2) begin e_cs = 1; e_wr = 1; e_addr = 5'h08; e_dout = m_b; end
                else if (t == 3) begin e_cs = 1; e_wr = 1; e_addr = 5'h0C; e_dout = 16'h1; end
                else if (t <= tt && (t - 3) % (G + 1) == 0) begin e_cs = 1; e_rd = 1; e_addr = 5'h14; end
                else if (m_k != 0 && t == tt + 1) begin e_cs = 1; e_rd = 1; e_addr = 5'h10; end
                else if (t == fin - 1) begin e_cs = 1; e_wr = 1; e_addr = 5'h0C; e_dout = 16'h0; end
                if (t == fin) begin
                    e_rv = 1;
                    e_res = (m_k != 0) ? 32'(m_a) * 32'(m_b) : 32'h0;
                    e_err = (m_k == 0);
                end
            end
            check($sformatf("cycle%0d", cyc),
                  {5'b0, busy, result_valid, error, cs, rd, wr, addr, d_out, result},
                  {5'b0, e_busy, e_rv, e_err, e_cs, e_rd, e_wr, e_addr, e_dout, e_res});
            if (reset) begin
                m_active = 0; m_res = '0; m_err = 0;
            end else begin
                if (m_active && t == fin) begin m_res = e_res; m_err = e_err; end
                if (start && (!m_active || t > fin)) begin
                    m_active = 1; m_s = cyc; m_a = op_a; m_b = op_b; m_k = done_after;
                end
            end
        end
    end

    task automatic drive_start(input logic [15:0] a, input logic [15:0] b);
        @(posedge clk); #2;
        start = 1; op_a = a; op_b = b; start_cyc = cyc;
        @(posedge clk); #2;
        start = 0;
    endtask

    task automatic wait_rv(input int max, output int lat);
        lat = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1) begin
                lat = cyc - start_cyc;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL wait_result_valid actual=none required=pulse within %0d cycles", max);
    endtask

    initial begin
        int lat, cnt;
        bit found;
        repeat (3) @(posedge clk);
        #2 reset = 0;
        repeat (2) @(posedge clk);

        // Basic multiply, done at first poll
        done_after = 1;
        drive_start(16'h0003, 16'h0007);
        wait_rv(60, lat);
        check("basic_latency", 64'(lat), 64'd9);
        check("basic_result", 64'(result), 64'h15);
        check("basic_error", 64'(error), 64'd0);
        check("basic_polls", 64'(p_polls), 64'd1);
        check("basic_a_b", {32'h0, p_a, p_b}, 64'h0003_0007);

        // Max operands, done at third poll
        done_after = 3;
        drive_start(16'hFFFF, 16'hFFFF);
        wait_rv(60, lat);
        check("max_result", 64'(result), 64'hFFFE0001);
        check("max_polls", 64'(p_polls), 64'd3);
        check("max_latency", 64'(lat), 64'd15);

        // Start during POLL is ignored
        done_after = 2;
        drive_start(16'd4, 16'd6);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(posedge clk); #2;
            if (cs && rd && addr == 5'h14) found = 1;
        end
        check("busy_poll_seen", 64'(found), 64'd1);
        start = 1; op_a = 16'd9; op_b = 16'd9;
        @(posedge clk); #2;
        start = 0;
        wait_rv(60, lat);
        check("busy_result", 64'(result), 64'h18);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (result_valid || busy) cnt++;
        end
        check("busy_single_rv", 64'(cnt), 64'd0);

        // Timeout: done never set
        done_after = 0;
        drive_start(16'd5, 16'd5);
        wait_rv(60, lat);
        check("to_latency", 64'(lat), 64'd17);
        check("to_error", 64'(error), 64'd1);
        check("to_result", 64'(result), 64'd0);
        check("to_polls", 64'(p_polls), 64'd4);

        // Back-to-back start in the cycle after FIN
        done_after = 1;
        drive_start(16'd2, 16'd5);
        wait_rv(60, lat);
        check("b2b_latency", 64'(lat), 64'd9);
        check("b2b_result", 64'(result), 64'hA);
        check("b2b_error", 64'(error), 64'd0);

        // Reset for two cycles during GAP
        done_after = 1;
        drive_start(16'd1, 16'd1);
        repeat (3) begin @(posedge clk); #2; end
        reset = 1;
        repeat (2) begin @(posedge clk); #2; end
        reset = 0;
        check("rst_result", 64'(result), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cs || rd || wr || busy || result_valid) cnt++;
        end
        check("rst_quiet", 64'(cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_bus_master.md
# mult_bus_master

Bus initiator that drives a memory-mapped multiplier peripheral on the femtoRV peripheral bus (cs/addr/rd/wr, 16-bit write data, 32-bit read data). A single start pulse with two 16-bit operands makes it write A, write B, raise init, poll done, read the 32-bit result, clear init and return the product. It lets hardware blocks, not only the CPU, use the multiplier. It sits between a client and the multiplier's bus port.

## Interface
- POLL_GAP, 2: idle cycles before each done poll (≥1).
- MAX_POLLS, 64: polls without done before timeout (≥1).
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request pulse; accepted only when busy=0.
- op_a  in  16  operand A, sampled with accepted start.
- op_b  in  16  operand B, sampled with accepted start.
- busy  out  1  high from cycle after accepted start through the result_valid cycle.
- result  out  32  product; held until next result_valid.
- result_valid  out  1  one-cycle pulse when result/error are valid.
- error  out  1  timeout flag, valid with result_valid, held until next result_valid.
- cs  out  1  bus chip select.
- addr  out  5  bus address.
- rd  out  1  bus read strobe.
- wr  out  1  bus write strobe.
- d_out  out  16  bus write data, to peripheral d_in.
- d_in  in  32  bus read data, from peripheral d_out.

## Operation
- Register map targeted: 0x04 A (W), 0x08 B (W), 0x0C init (W, bit0), 0x10 result (R), 0x14 done (R, bit0).
- Every bus access lasts exactly one cycle with cs=1 and exactly one of rd/wr=1.
- Writes: the peripheral captures d_out at the closing edge.
- Reads: d_in is sampled at the closing edge of the rd cycle.
- Outside an access: cs=rd=wr=0, addr=0, d_out=0.
- States and transitions:
  - IDLE: on start, latch op_a/op_b and go to WR_A.
  - WR_A: write addr 0x04, d_out=op_a. Go to WR_B.
  - WR_B: write addr 0x08, d_out=op_b. Go to WR_INIT.
  - WR_INIT: write addr 0x0C, d_out=16'h0001. Clear the poll counter. Go to GAP.
  - GAP: no bus activity for POLL_GAP cycles, then POLL.
  - POLL: read addr 0x14 and increment the poll counter.
    - d_in[0]=1 → RD_RES.
    - Else, counter=MAX_POLLS → set timeout, go to CLR_INIT.
    - Else → GAP.
  - RD_RES: read addr 0x10 and latch d_in into the result holding register. Go to CLR_INIT.
  - CLR_INIT: write addr 0x0C, d_out=16'h0000. Go to FIN.
  - FIN: result_valid=1 and busy=1. Result is the latched value, or 0 on timeout; error=timeout. Go to IDLE.
- start while busy is ignored. It is not queued.
- Start asserted in the FIN cycle is also ignored; start is only accepted in IDLE.
- The poll counter width is clog2(MAX_POLLS+1). It does not wrap.
- init is always returned to 0 before FIN, including on timeout.

## Timing
- Reset values: busy=0, result=0, result_valid=0, error=0, cs=rd=wr=0, addr=0, d_out=0. State is IDLE.
- Reset mid-operation aborts on the next edge. The peripheral's init is not cleared by this block; the peripheral's own reset handles it.
- All outputs are registered (Moore). Bus signals change only on clk edges.
- Start accepted at edge 0 → WR_A is cycle 1, WR_B is cycle 2, WR_INIT is cycle 3, GAP is cycles 4..3+POLL_GAP, first POLL is cycle 4+POLL_GAP.
- If done is seen at poll k (k from 1), latency from start to result_valid is:
  - 6 + k·(POLL_GAP+1) cycles.
  - Default POLL_GAP=2 with done at first poll → result_valid in cycle 9.
- Timeout: result_valid with error=1 at cycle 5 + MAX_POLLS·(POLL_GAP+1).
- Back-to-back jobs: the next start is accepted at the earliest in the cycle after FIN.

## Test plan
- Reset: assert reset for 2 cycles mid-job (during GAP). → All outputs 0 the next cycle, busy=0, no further bus activity.
- Basic multiply: op_a=16'h0003, op_b=16'h0007; peripheral model sets done on the first poll with result 32'h15.
  - Exact bus sequence: W04=3, W08=7, W0C=1, R14, R10, W0C=0.
  - result=32'h00000015, error=0, result_valid in cycle 9.
- Max operands: op_a=op_b=16'hFFFF; done after 3 polls.
  - result=32'hFFFE0001.
  - Exactly 3 reads of 0x14, with 2 idle cycles before each.
- Timeout: MAX_POLLS=4 and done never set.
  - Exactly 4 polls, then W0C=0.
  - result_valid with error=1, result=0, at cycle 17.
- start while busy: pulse start with new operands during POLL. → Ignored; the original operands complete, with a single result_valid.
- Back-to-back: start again the cycle after FIN with op_a=2, op_b=5. → Accepted; the second result is 32'hA, and error from the previous job is cleared on the new result_valid.
